// File: rtl/bcd_pkg.sv
// Shared types and constants for the cascaded BCD counter.
package bcd_pkg;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [DIGIT_W-1:0] bcd_step(input logic [DIGIT_W-1:0] d, input logic up);
    if (up) return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

  function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/bcd_counter_ctrl_if.sv
// Command, preset and status bundle between a controller and the BCD counter.
interface bcd_counter_ctrl_if #(parameter int NUM_DIGITS = 4);

  logic                    tick;
  logic                    start;
  logic                    stop;
  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_value;
  logic                    up;
  logic [4*NUM_DIGITS-1:0] limit;
  logic [4*NUM_DIGITS-1:0] digits;
  logic                    carry;
  logic                    running;
  logic                    done;

  modport master (
    output tick, start, stop, clear, load, load_value, up, limit,
    input  digits, carry, running, done
  );

  modport slave (
    input  tick, start, stop, clear, load, load_value, up, limit,
    output digits, carry, running, done
  );

endinterface

// File: rtl/bcd_digit_updown.sv
// One BCD digit with load and up/down step; carry_out is the combinational
// carry (up) or borrow (down) that enables the next digit in the chain.
module bcd_digit_updown
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_d,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out
);

  assign carry_out = en & (up ? (q == BCD_MAX) : (q == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= bcd_sanitize(load_d);
    else if (en)   q <= bcd_step(q, up);
  end

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Cascaded BCD up/down counter with start/stop/clear/load control and
// terminal-value detection.
//
// state    | meaning
// ST_IDLE  | stopped, digits loadable, waiting for start
// ST_RUN   | counting on tick, watching for limit
// ST_PAUSE | stopped mid-count, digits loadable, start resumes
// ST_DONE  | limit reached, frozen until clear
module bcd_counter_ctrl
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_counter_ctrl_if.slave   bus
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  logic [1:0]            rst_sync;
  logic                  rst_int;
  state_t                state;
  logic                  carry_r, running_r, done_r;
  logic [NUM_DIGITS-1:0] en_chain;
  logic [NUM_DIGITS-1:0] cout;
  logic [W-1:0]          q_all;
  logic [W-1:0]          next_count;
  logic [W-1:0]          dig_load_d;
  logic                  dig_load;
  logic                  count_en;
  logic                  wrap;

  // Assert immediately, release only after two clean clk edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  always_comb begin
    dig_load   = 1'b0;
    dig_load_d = '0;
    count_en   = 1'b0;
    if (bus.clear) begin
      dig_load = 1'b1;
    end else if (bus.load && (state == ST_IDLE || state == ST_PAUSE)) begin
      dig_load   = 1'b1;
      dig_load_d = bus.load_value;
    end else if (state == ST_RUN && bus.tick && !bus.stop && !bus.start) begin
      count_en = 1'b1;
    end
  end

  assign en_chain[0] = count_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_updown u_digit (
      .clk       (clk),
      .rst       (rst_int),
      .en        (en_chain[g]),
      .up        (bus.up),
      .load      (dig_load),
      .load_d    (dig_load_d[DIGIT_W*g +: DIGIT_W]),
      .q         (q_all[DIGIT_W*g +: DIGIT_W]),
      .carry_out (cout[g])
    );
    assign next_count[DIGIT_W*g +: DIGIT_W] =
      en_chain[g] ? bcd_step(q_all[DIGIT_W*g +: DIGIT_W], bus.up)
                  : q_all[DIGIT_W*g +: DIGIT_W];
    if (g < NUM_DIGITS-1) begin : g_chain
      assign en_chain[g+1] = cout[g];
    end
  end

  assign wrap = cout[NUM_DIGITS-1];

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state     <= ST_IDLE;
      carry_r   <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      carry_r <= 1'b0;
      if (bus.clear) begin
        state     <= ST_IDLE;
        running_r <= 1'b0;
        done_r    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_PAUSE: begin
            if (!bus.load && bus.start) begin
              state     <= ST_RUN;
              running_r <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.stop) begin
              state     <= ST_PAUSE;
              running_r <= 1'b0;
            end else if (count_en) begin
              carry_r <= wrap;
              // Compare the value being written, so done rises with digits.
              if (next_count == bus.limit) begin
                state     <= ST_DONE;
                running_r <= 1'b0;
                done_r    <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.digits  = q_all;
  assign bus.carry   = carry_r;
  assign bus.running = running_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed-vector bench for bcd_counter_ctrl with four digits.
module tb_bcd_counter_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic carry_seen;

  bcd_counter_ctrl_if #(.NUM_DIGITS(4)) bus ();

  bcd_counter_ctrl #(.NUM_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; cyc(); bus.clear = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load_value = v; bus.load = 1'b1; cyc(); bus.load = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
      carry_seen |= bus.carry;
    end
  endtask

  initial begin
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0;
    bus.load_value = '0; bus.up = 1'b1; bus.limit = 16'h5000;
    cyc(3);
    chk("rst_digits",  32'(bus.digits), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_done",    32'(bus.done), 32'h0);
    chk("rst_carry",   32'(bus.carry), 32'h0);
    rst = 1'b0;
    cyc(3);

    // 12 up ticks from zero
    do_start();
    chk("a_running", 32'(bus.running), 32'h1);
    carry_seen = 1'b0;
    do_tick(12);
    chk("a_digits",  32'(bus.digits), 32'h0012);
    chk("a_running2", 32'(bus.running), 32'h1);
    chk("a_nocarry", 32'(carry_seen), 32'h0);

    // Full up wrap
    do_clear();
    chk("b_clear_digits",  32'(bus.digits), 32'h0);
    chk("b_clear_running", 32'(bus.running), 32'h0);
    do_load(16'h9998);
    chk("b_load", 32'(bus.digits), 32'h9998);
    do_start();
    do_tick(1);
    chk("b_t1_digits", 32'(bus.digits), 32'h9999);
    chk("b_t1_carry",  32'(bus.carry), 32'h0);
    do_tick(1);
    chk("b_t2_digits", 32'(bus.digits), 32'h0000);
    chk("b_t2_carry",  32'(bus.carry), 32'h1);
    cyc();
    chk("b_carry_drop", 32'(bus.carry), 32'h0);

    // Full down wrap
    do_clear();
    do_load(16'h0000);
    bus.up = 1'b0;
    do_start();
    do_tick(1);
    chk("c_digits", 32'(bus.digits), 32'h9999);
    chk("c_carry",  32'(bus.carry), 32'h1);
    bus.up = 1'b1;
    do_tick(1);
    chk("c_up_again", 32'(bus.digits), 32'h0000);

    // Limit reached with digit carry
    do_clear();
    bus.limit = 16'h0060;
    do_load(16'h0057);
    do_start();
    do_tick(2);
    chk("d_59_digits", 32'(bus.digits), 32'h0059);
    chk("d_59_done",   32'(bus.done), 32'h0);
    do_tick(1);
    chk("d_60_digits",  32'(bus.digits), 32'h0060);
    chk("d_60_done",    32'(bus.done), 32'h1);
    chk("d_60_running", 32'(bus.running), 32'h0);
    do_tick(1);
    chk("d_frozen", 32'(bus.digits), 32'h0060);
    do_load(16'h0011);
    chk("d_load_ignored", 32'(bus.digits), 32'h0060);

    // Starting already at limit must not finish
    do_clear();
    chk("d_clear_done", 32'(bus.done), 32'h0);
    do_load(16'h0060);
    do_start();
    chk("e_at_limit_done", 32'(bus.done), 32'h0);
    chk("e_at_limit_run",  32'(bus.running), 32'h1);
    do_tick(1);
    chk("e_past_limit", 32'(bus.digits), 32'h0061);

    // tick+stop, pause, out-of-range load
    do_clear();
    bus.limit = 16'h5000;
    do_load(16'h0010);
    do_start();
    bus.tick = 1'b1; bus.stop = 1'b1; cyc(); bus.tick = 1'b0; bus.stop = 1'b0;
    chk("f_stop_digits",  32'(bus.digits), 32'h0010);
    chk("f_stop_running", 32'(bus.running), 32'h0);
    do_tick(1);
    chk("f_pause_hold", 32'(bus.digits), 32'h0010);
    do_load(16'h12A4);
    chk("f_bad_digit", 32'(bus.digits), 32'h1204);
    do_start();
    do_tick(1);
    chk("f_resume", 32'(bus.digits), 32'h1205);

    // Async reset mid-run
    do_clear();
    do_load(16'h0345);
    do_start();
    #2 rst = 1'b1;
    #1;
    chk("g_rst_digits",  32'(bus.digits), 32'h0);
    chk("g_rst_running", 32'(bus.running), 32'h0);
    cyc(2);
    rst = 1'b0;
    cyc(3);
    do_tick(3);
    chk("g_no_count", 32'(bus.digits), 32'h0);
    chk("g_idle",     32'(bus.running), 32'h0);
    do_start();
    do_tick(1);
    chk("g_count_after_start", 32'(bus.digits), 32'h0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_counter_ctrl.md
BCD_COUNTER_CTRL -- requirements
Module: bcd_counter_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of cascaded BCD digits, legal range 1..8.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  count-enable strobe, one clk wide; sampled only in RUN.
REQ-005 start  input  1  command pulse: enter or resume counting.
REQ-006 stop  input  1  command pulse: pause counting.
REQ-007 clear  input  1  command pulse: zero the digits and go to IDLE.
REQ-008 load  input  1  command pulse: preset the digits from load_value.
REQ-009 load_value  input  4*NUM_DIGITS  packed BCD preset; digit 0 in bits [3:0].
REQ-010 up  input  1  count direction; 1=increment, 0=decrement; sampled per tick.
REQ-011 limit  input  4*NUM_DIGITS  packed BCD terminal value.
REQ-012 digits  output  4*NUM_DIGITS  current packed BCD count.
REQ-013 carry  output  1  one-cycle pulse on whole-counter wrap.
REQ-014 running  output  1  high while in RUN.
REQ-015 done  output  1  high while in DONE.

Function
REQ-016 FSM states: IDLE, RUN, PAUSE, DONE; state is registered.
REQ-017 IDLE: start -> RUN; load -> stay in IDLE with digits = load_value.
REQ-018 RUN: stop -> PAUSE; tick with the next count equal to limit -> DONE; otherwise stay in RUN.
REQ-019 PAUSE: start -> RUN; load -> stay in PAUSE with digits = load_value.
REQ-020 DONE: start, stop, load and tick are ignored; only clear leaves DONE.
REQ-021 clear in any state -> IDLE with digits = 0 on the next edge.
REQ-022 Same-cycle command priority: clear > load > stop > start > tick.
REQ-023 load in RUN or DONE is ignored.
REQ-024 Loading an out-of-range digit (value > 9) stores 0 for that digit; other digits load normally.
REQ-025 Counting happens only in RUN, on a cycle with tick=1 and no higher-priority command; digits update on the same clk edge that samples tick, i.e. one cycle of latency.
REQ-026 Up count: each digit cycles 9 -> 0 and carries into the next digit. All 9s -> all 0s; carry pulses for that one cycle.
REQ-027 Down count: each digit cycles 0 -> 9 and borrows from the next digit. All 0s -> all 9s; carry pulses for that one cycle.
REQ-028 The limit compare uses the next-count value: digits==limit and done rise on the same edge.
REQ-029 A wrap whose result equals limit asserts carry and enters DONE on the same edge.
REQ-030 Entering RUN with digits already equal to limit does not trigger DONE; only a tick that lands on limit does.
REQ-031 carry is 0 in every cycle without a wrap.
REQ-032 tick=1 and stop=1 in the same RUN cycle: stop wins, no count, go to PAUSE.

Reset
REQ-033 rst=1 forces, asynchronously: state=IDLE, digits=0, carry=0, running=0, done=0.
REQ-034 Reset asserted mid-count discards the count in progress; after release, counting resumes only on a new start.
REQ-035 Reset release is synchronised to clk inside the block before it reaches the FSM.

Structure
REQ-036 Shared package bcd_pkg holds the FSM state enum, BCD_MAX=4'd9 and the DIGIT_W=4 constant.
REQ-037 One sub-module, bcd_digit_updown, instantiated NUM_DIGITS times as a ripple chain: inputs en, up, load, load_d; outputs q, carry_out.
REQ-038 Digit chaining uses the combinational carry/borrow of each digit; the whole counter updates in a single edge.

Verification (NUM_DIGITS=4)
REQ-039 Reset, start, 12 ticks, up=1 -> digits=0x0012, running=1, carry never asserted.
REQ-040 load 0x9998 in IDLE, start, 2 ticks, up=1, limit=0x5000 -> digits 0x9999 then 0x0000; carry high for exactly the second tick's cycle.
REQ-041 load 0x0000, start, 1 tick, up=0 -> digits=0x9999, carry pulse.
REQ-042 load 0x0057, limit=0x0060, start, 3 ticks -> done=1 and running=0 on the edge where digits=0x0060; a 4th tick leaves digits at 0x0060.
REQ-043 In RUN, tick+stop together -> no count, PAUSE; then load 0x12A4 -> digits=0x1204.
REQ-044 rst pulsed asynchronously mid-RUN at 0x0345 -> outputs zero immediately; ticks after release do not count until start.
